imem_program_loader: RTL and testbench

- Writer-side counterpart to the PC-driven instruction fetch path.
- Accepts a stream of 32-bit instruction words over a valid/ready interface and writes them sequentially into instruction memory from address 0.
- Holds the core in reset while loading, and releases it once the last word is committed.
- Sits between the host/testbench stream source and the imem write port.

---
 rtl/imem_program_loader.sv | 157 +++++++++++++++
 tb/tb_imem_program_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Writes a stream of instruction words into instruction memory, starting at
// word address 0, and holds the core in reset while doing so. The core is
// released once the program's final word has been presented to memory.
//
// Parameters
//   ADDR_W  instruction memory word-address width (matches the PC width)
//   DATA_W  instruction word width
//   DEPTH   number of writable words; must not exceed 2**ADDR_W
//
// Ports
//   clk           system clock, rising-edge
//   reset         asynchronous, active-low reset
//   start         one-cycle pulse that opens a load session (ignored in LOAD)
//   s_valid       stream word valid
//   s_data        stream instruction word
//   s_last        marks s_data as the final word of the program
//   s_ready       loader accepts a word this cycle (high only in LOAD)
//   imem_wr_en    instruction memory write strobe (one cycle per accepted word)
//   imem_wr_addr  write word address
//   imem_wr_data  write data
//   core_rst_n    active-low reset to the core; high only in DONE
//   busy          high in LOAD
//   done          high in DONE
//   error         high in ERROR (program overflowed DEPTH)
//   word_cnt      words accepted this session
//   checksum      sum of accepted words, mod 2**DATA_W
//   state_dbg     current FSM state encoding (IDLE=0, LOAD=1, DONE=2, ERROR=3)
//
// Stream handshake: a word transfers on a rising edge where s_valid and
// s_ready are both high. s_ready is a pure function of the state and never
// depends on s_valid; s_data/s_last are only looked at on a transfer edge.
// -----------------------------------------------------------------------------
module imem_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [DATA_W-1:0] imem_wr_data,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt,
  output logic [DATA_W-1:0] checksum,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Address of the last writable word; a non-final word landing here means
  // the program does not fit.
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              handshake;
  logic              session_start;

  assign handshake     = s_valid && s_ready;
  // start only opens a session outside LOAD; a pulse mid-load is dropped.
  assign session_start = start && (state != ST_LOAD);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (handshake) begin
          if (s_last) begin
            state_nxt = ST_DONE;
          end else if (wr_ptr == LAST_SLOT) begin
            // The overflowing word itself is still written.
            state_nxt = ST_ERROR;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs. core_rst_n rises on the same edge that enters DONE,
  // which is also the edge that registers the final write, so the core never
  // leaves reset before its last instruction is presented to memory.
  // ---------------------------------------------------------------------------
  assign s_ready    = (state == ST_LOAD);
  assign busy       = (state == ST_LOAD);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERROR);
  assign core_rst_n = (state == ST_DONE);
  assign state_dbg  = state;

  // ---------------------------------------------------------------------------
  // Write port and session counters. The write is registered: an accepted
  // word appears on the imem port in the cycle after its handshake.
  // Counters cannot wrap: the FSM leaves LOAD no later than the handshake at
  // LAST_SLOT, so word_cnt tops out at DEPTH.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      wr_ptr       <= '0;
      word_cnt     <= '0;
      checksum     <= '0;
    end else begin
      imem_wr_en <= handshake;
      if (session_start) begin
        wr_ptr   <= '0;
        word_cnt <= '0;
        checksum <= '0;
      end else if (handshake) begin
        imem_wr_addr <= wr_ptr;
        imem_wr_data <= s_data;
        wr_ptr       <= wr_ptr + 1'b1;
        word_cnt     <= word_cnt + 1'b1;
        checksum     <= checksum + s_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
//
// Directed bench for imem_program_loader built with DEPTH=4 so the overflow
// path is reachable. Each accepted word pushes its expected imem write
// {core_rst_n, addr, data} into exp_q; an independent monitor pops and
// compares on every cycle that presents imem_wr_en.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int W      = 1 + ADDR_W + DATA_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [DATA_W-1:0] imem_wr_data;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_cnt;
  logic [DATA_W-1:0] checksum;
  logic [1:0]        state_dbg;

  imem_program_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .word_cnt     (word_cnt),
    .checksum     (checksum),
    .state_dbg    (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           wr_seen  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every imem write must match the head of the expected queue.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (imem_wr_en === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 imem_wr_addr, imem_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_wr_addr, e[DATA_W +: ADDR_W]);
        check("wr_data", imem_wr_data, e[DATA_W-1:0]);
        check("core_rst_n_at_write", core_rst_n, e[W-1]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one word, waits for the handshake edge, then idles for gap cycles.
  // addr is the hand-computed write address; rel is the expected core_rst_n
  // in the write cycle (1 only for the word that completes the program).
  task automatic send_word(input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] d, input logic last,
                           input logic rel, input int gap);
    int budget;
    budget  = 50;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready=%0b, required 1 within 50 cycles", s_ready);
    end else begin
      exp_q.push_back({rel, addr, d});
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;

    // Reset values
    #3;
    check("rst_state",      state_dbg, 2'd0);
    check("rst_s_ready",    s_ready, 0);
    check("rst_wr_en",      imem_wr_en, 0);
    check("rst_wr_addr",    imem_wr_addr, 0);
    check("rst_wr_data",    imem_wr_data, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_busy",       busy, 0);
    check("rst_done",       done, 0);
    check("rst_error",      error, 0);
    check("rst_word_cnt",   word_cnt, 0);
    check("rst_checksum",   checksum, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_s_ready",    s_ready, 0);
    check("idle_core_rst_n", core_rst_n, 0);

    // Basic load
    pulse_start();
    check("load_busy",    busy, 1);
    check("load_s_ready", s_ready, 1);
    send_word(8'd0, 32'h00100093, 1'b0, 1'b0, 0);
    send_word(8'd1, 32'h00100094, 1'b0, 1'b0, 0);
    send_word(8'd2, 32'h00200113, 1'b1, 1'b1, 0);
    check("basic_done",       done, 1);
    check("basic_busy",       busy, 0);
    check("basic_s_ready",    s_ready, 0);
    check("basic_core_rst_n", core_rst_n, 1);
    check("basic_word_cnt",   word_cnt, 3);
    check("basic_checksum",   checksum, 32'h0040023A);
    check("basic_state",      state_dbg, 2'd2);

    // Backpressure / gaps
    pulse_start();
    check("gap_start_core_rst_n", core_rst_n, 0);
    check("gap_start_word_cnt",   word_cnt, 0);
    check("gap_start_checksum",   checksum, 0);
    check("gap_start_done",       done, 0);
    base = wr_seen;
    send_word(8'd0, 32'h00100093, 1'b0, 1'b0, 2);
    send_word(8'd1, 32'h00100094, 1'b0, 1'b0, 2);
    send_word(8'd2, 32'h00200113, 1'b1, 1'b1, 0);
    @(negedge clk); #1;
    check("gap_write_count", wr_seen - base, 3);
    check("gap_done",        done, 1);
    check("gap_word_cnt",    word_cnt, 3);
    check("gap_checksum",    checksum, 32'h0040023A);

    // start during LOAD is ignored
    @(posedge clk); #1;
    pulse_start();
    send_word(8'd0, 32'h00100093, 1'b0, 1'b0, 0);
    pulse_start();
    check("midstart_busy",     busy, 1);
    check("midstart_word_cnt", word_cnt, 1);
    check("midstart_checksum", checksum, 32'h00100093);
    send_word(8'd1, 32'h00100094, 1'b0, 1'b0, 0);
    send_word(8'd2, 32'h00200113, 1'b1, 1'b1, 0);
    check("midstart_done",     done, 1);
    check("midstart_cnt_end",  word_cnt, 3);
    check("midstart_cs_end",   checksum, 32'h0040023A);

    // Reload after DONE
    pulse_start();
    check("reload_core_rst_n", core_rst_n, 0);
    check("reload_done",       done, 0);
    check("reload_busy",       busy, 1);
    send_word(8'd0, 32'h00000013, 1'b1, 1'b1, 0);
    check("reload_done_end",   done, 1);
    check("reload_word_cnt",   word_cnt, 1);
    check("reload_checksum",   checksum, 32'h00000013);
    check("reload_rel",        core_rst_n, 1);

    // Overflow: DEPTH=4, no s_last
    pulse_start();
    send_word(8'd0, 32'h11111111, 1'b0, 1'b0, 0);
    send_word(8'd1, 32'h22222222, 1'b0, 1'b0, 0);
    send_word(8'd2, 32'h33333333, 1'b0, 1'b0, 0);
    send_word(8'd3, 32'h44444444, 1'b0, 1'b0, 0);
    check("ovf_error",      error, 1);
    check("ovf_s_ready",    s_ready, 0);
    check("ovf_core_rst_n", core_rst_n, 0);
    check("ovf_word_cnt",   word_cnt, 4);
    check("ovf_checksum",   checksum, 32'hAAAAAAAA);
    check("ovf_state",      state_dbg, 2'd3);
    s_valid = 1'b1;
    s_data  = 32'h55555555;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("ovf_hold_s_ready",  s_ready, 0);
    check("ovf_hold_word_cnt", word_cnt, 4);
    check("ovf_hold_error",    error, 1);
    s_valid = 1'b0;
    s_data  = '0;

    // Reset mid-load
    pulse_start();
    send_word(8'd0, 32'hA0000001, 1'b0, 1'b0, 0);
    send_word(8'd1, 32'hB0000002, 1'b0, 1'b0, 0);
    @(negedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'hC0000003;
    s_last  = 1'b1;
    reset   = 1'b0;
    #1;
    check("abort_state",      state_dbg, 2'd0);
    check("abort_s_ready",    s_ready, 0);
    check("abort_wr_en",      imem_wr_en, 0);
    check("abort_wr_addr",    imem_wr_addr, 0);
    check("abort_wr_data",    imem_wr_data, 0);
    check("abort_busy",       busy, 0);
    check("abort_core_rst_n", core_rst_n, 0);
    check("abort_word_cnt",   word_cnt, 0);
    check("abort_checksum",   checksum, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_idle_state",   state_dbg, 2'd0);
    check("abort_idle_s_ready", s_ready, 0);
    check("abort_idle_cnt",     word_cnt, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;

    // Drain
    @(negedge clk); #1;
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
